// File: rtl/cdr_pkg.sv
// Shared CDR constants and lock-FSM encoding used by the delay-line
// controller and the phase-detector top.
package cdr_pkg;

  localparam int N_TAPS      = 32;
  localparam int TAP_W       = $clog2(N_TAPS);
  localparam int FILT_TH     = 8;
  localparam int LOCK_CYCLES = 64;
  localparam int TAP_RESET   = N_TAPS / 2;

  typedef enum logic {
    ACQ  = 1'b0,
    LOCK = 1'b1
  } lock_state_e;

  // Signed accumulator width able to hold -th..+th.
  function automatic int acc_width(input int th);
    return $clog2(th + 1) + 1;
  endfunction

endpackage

// File: rtl/delay_line_controller_if.sv
// Phase-detector <-> delay-line controller bundle: votes and freeze in,
// tap select, step pulses, range flags and lock indication out.
interface delay_line_controller_if #(
  parameter int TAP_W = cdr_pkg::TAP_W
);

  logic             shift_left;
  logic             shift_right;
  logic             freeze;
  logic [TAP_W-1:0] tap_sel;
  logic             step_left;
  logic             step_right;
  logic             at_min;
  logic             at_max;
  logic             locked;

  modport master (
    output shift_left, shift_right, freeze,
    input  tap_sel, step_left, step_right, at_min, at_max, locked
  );

  modport slave (
    input  shift_left, shift_right, freeze,
    output tap_sel, step_left, step_right, at_min, at_max, locked
  );

endinterface

// File: rtl/delay_line_controller_rw_filter.sv
// Random-walk filter: integrates early/late votes and emits a one-cycle
// threshold pulse (combinational, same cycle as the deciding vote).
module rw_filter #(
  parameter int FILT_TH = cdr_pkg::FILT_TH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic                                          vote_up,
  input  logic                                          vote_dn,
  output logic signed [cdr_pkg::acc_width(FILT_TH)-1:0] acc,
  output logic                                          thr_up,
  output logic                                          thr_dn
);

  localparam int ACC_W = cdr_pkg::acc_width(FILT_TH);
  localparam logic signed [ACC_W-1:0] ONE    = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] TH_POS = ACC_W'(FILT_TH);
  localparam logic signed [ACC_W-1:0] TH_NEG = -TH_POS;

  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] acc_d;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    acc_sum = acc;
    thr_up  = 1'b0;
    thr_dn  = 1'b0;
    if (en) begin
      if (vote_up && !vote_dn)
        acc_sum = acc + ONE;
      else if (vote_dn && !vote_up)
        acc_sum = acc - ONE;
      thr_up = (acc_sum == TH_POS);
      thr_dn = (acc_sum == TH_NEG);
    end
    acc_d = (thr_up || thr_dn) ? '0 : acc_sum;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst)
      acc <= '0;
    else
      acc <= acc_d;
  end

endmodule

// File: rtl/delay_line_controller.sv
// Delay-line controller: filtered votes move a saturating tap pointer; a
// step-free run of LOCK_CYCLES unfrozen cycles declares lock.
module delay_line_controller #(
  parameter int N_TAPS      = cdr_pkg::N_TAPS,
  parameter int FILT_TH     = cdr_pkg::FILT_TH,
  parameter int LOCK_CYCLES = cdr_pkg::LOCK_CYCLES,
  parameter int TAP_RESET   = cdr_pkg::TAP_RESET
) (
  input logic                    clk,
  input logic                    rst,
  delay_line_controller_if.slave dl
);

  import cdr_pkg::*;

  localparam int TAP_W = $clog2(N_TAPS);
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam int ACC_W = acc_width(FILT_TH);

  localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(N_TAPS - 1);
  localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(TAP_RESET);
  localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_CYCLES);

  logic signed [ACC_W-1:0] acc;
  logic                    thr_up;
  logic                    thr_dn;

  logic [TAP_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lock_state_e      state_q, state_d;
  logic             inc, dec, step_evt;
  logic             step_left_q, step_right_q, at_min_q, at_max_q;

  rw_filter #(
    .FILT_TH (FILT_TH)
  ) u_filt (
    .clk     (clk),
    .rst     (rst),
    .en      (!dl.freeze),
    .vote_up (dl.shift_right),
    .vote_dn (dl.shift_left),
    .acc     (acc),
    .thr_up  (thr_up),
    .thr_dn  (thr_dn)
  );

  // A threshold hit at a range end is still a step for lock purposes, even
  // though the pointer cannot move.
  always_comb begin
    inc      = thr_up && (tap_q != TAP_MAX);
    dec      = thr_dn && (tap_q != '0);
    step_evt = thr_up || thr_dn;
    tap_d    = tap_q;
    if (inc)
      tap_d = tap_q + TAP_W'(1);
    else if (dec)
      tap_d = tap_q - TAP_W'(1);

    cnt_d = cnt_q;
    if (!dl.freeze) begin
      if (step_evt)
        cnt_d = '0;
      else if (cnt_q < CNT_LOCK)
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACQ:  if (!dl.freeze && !step_evt && cnt_d == CNT_LOCK) state_d = LOCK;
      LOCK: if (step_evt) state_d = ACQ;
      default: state_d = ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACQ;
      tap_q        <= TAP_INIT;
      cnt_q        <= '0;
      step_left_q  <= 1'b0;
      step_right_q <= 1'b0;
      at_min_q     <= (TAP_INIT == '0);
      at_max_q     <= (TAP_INIT == TAP_MAX);
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      step_left_q  <= dec;
      step_right_q <= inc;
      at_min_q     <= (tap_d == '0);
      at_max_q     <= (tap_d == TAP_MAX);
    end
  end

  assign dl.tap_sel    = tap_q;
  assign dl.step_left  = step_left_q;
  assign dl.step_right = step_right_q;
  assign dl.at_min     = at_min_q;
  assign dl.at_max     = at_max_q;
  assign dl.locked     = (state_q == LOCK);

endmodule

// File: tb/tb_delay_line_controller.sv
// Self-checking bench for delay_line_controller: directed scenarios plus
// random votes, all compared against an arithmetic reference model.
module tb_delay_line_controller;

  import cdr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  delay_line_controller_if dl_if ();

  delay_line_controller u_dut (
    .clk (clk),
    .rst (rst),
    .dl  (dl_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (plain integers).
  int m_acc, m_tap, m_cnt;
  bit m_locked, m_sl, m_sr;

  task automatic model_edge(input bit r, input bit l, input bit rr, input bit f);
    int vote, nxt;
    bit stepped;
    if (r) begin
      m_acc = 0; m_tap = TAP_RESET; m_cnt = 0; m_locked = 0; m_sl = 0; m_sr = 0;
    end else if (f) begin
      m_sl = 0; m_sr = 0;
    end else begin
      vote    = (rr && !l) ? 1 : ((l && !rr) ? -1 : 0);
      nxt     = m_acc + vote;
      stepped = 0; m_sl = 0; m_sr = 0;
      if (nxt == FILT_TH) begin
        m_acc = 0; stepped = 1;
        if (m_tap < N_TAPS - 1) begin m_tap++; m_sr = 1; end
      end else if (nxt == -FILT_TH) begin
        m_acc = 0; stepped = 1;
        if (m_tap > 0) begin m_tap--; m_sl = 1; end
      end else begin
        m_acc = nxt;
      end
      if (stepped) begin
        m_cnt = 0; m_locked = 0;
      end else begin
        if (m_cnt < LOCK_CYCLES) m_cnt++;
        if (m_cnt == LOCK_CYCLES) m_locked = 1;
      end
    end
  endtask

  function automatic logic [TAP_W+4:0] exp_vec();
    return {TAP_W'(m_tap), m_sl, m_sr, (m_tap == 0), (m_tap == N_TAPS - 1), m_locked};
  endfunction

  function automatic logic [TAP_W+4:0] obs_vec();
    return {dl_if.tap_sel, dl_if.step_left, dl_if.step_right,
            dl_if.at_min, dl_if.at_max, dl_if.locked};
  endfunction

  task automatic cycle(input bit r, input bit l, input bit rr, input bit f);
    @(negedge clk);
    rst = r; dl_if.shift_left = l; dl_if.shift_right = rr; dl_if.freeze = f;
    @(posedge clk);
    #1;
    model_edge(r, l, rr, f);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [TAP_W+4:0] exp_c;
    do_reset();
    exp_c = {TAP_W'(16), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_vec++;
    if (obs_vec() !== exp_c) begin
      n_err++;
      $display("FAIL reset_state: got %b expected %b", obs_vec(), exp_c);
    end
  endtask

  task automatic test_right_step();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cycle(0, 0, (i <= 8), 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL right_step model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      n_vec++;
      if (dl_if.step_right !== (i == 8) || dl_if.tap_sel !== TAP_W'(i >= 8 ? 17 : 16)) begin
        n_err++;
        $display("FAIL right_step const cyc %0d: got tap %0d sr %b", i, dl_if.tap_sel, dl_if.step_right);
      end
    end
  endtask

  task automatic test_null_votes();
    do_reset();
    for (int i = 1; i <= 120; i++) begin
      if (i <= 100) cycle(0, (i % 2 == 0), (i % 2 == 1), 0);
      else          cycle(0, 1, 1, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL null_votes model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      n_vec++;
      if (dl_if.tap_sel !== TAP_W'(16) || dl_if.step_left !== 1'b0 ||
          dl_if.step_right !== 1'b0 || dl_if.locked !== (i >= 64)) begin
        n_err++;
        $display("FAIL null_votes const cyc %0d: got tap %0d locked %b", i, dl_if.tap_sel, dl_if.locked);
      end
    end
  endtask

  task automatic test_left_saturate();
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      cycle(0, 1, 0, 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL left_sat model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      n_vec++;
      if (dl_if.locked !== 1'b0 ||
          (i >= 128 && (dl_if.tap_sel !== '0 || dl_if.at_min !== 1'b1)) ||
          (i > 128 && dl_if.step_left !== 1'b0)) begin
        n_err++;
        $display("FAIL left_sat const cyc %0d: got tap %0d min %b sl %b locked %b",
                 i, dl_if.tap_sel, dl_if.at_min, dl_if.step_left, dl_if.locked);
      end
    end
  endtask

  task automatic test_relock();
    do_reset();
    for (int i = 1; i <= 64 + 8 + 64; i++) begin
      cycle(0, 0, (i > 64 && i <= 72), 0);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL relock model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      n_vec++;
      if (dl_if.locked !== ((i >= 64 && i < 72) || i >= 136) ||
          dl_if.step_right !== (i == 72)) begin
        n_err++;
        $display("FAIL relock const cyc %0d: got locked %b sr %b", i, dl_if.locked, dl_if.step_right);
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    for (int i = 1; i <= 28; i++) begin
      cycle(0, 0, 1, (i <= 20));
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL freeze model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
      n_vec++;
      if (dl_if.step_right !== (i == 28) || dl_if.tap_sel !== TAP_W'(i == 28 ? 17 : 16)) begin
        n_err++;
        $display("FAIL freeze const cyc %0d: got tap %0d sr %b", i, dl_if.tap_sel, dl_if.step_right);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 39; i++) cycle(0, 0, 1, 0);
    n_vec++;
    if (dl_if.tap_sel !== TAP_W'(20) || obs_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_mid setup: got %b expected %b", obs_vec(), exp_vec());
    end
    cycle(1, 0, 1, 1);
    n_vec++;
    if (obs_vec() !== {TAP_W'(16), 5'b00000}) begin
      n_err++;
      $display("FAIL reset_mid override: got %b expected %b", obs_vec(), {TAP_W'(16), 5'b00000});
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, 0);
      n_vec++;
      if (obs_vec() !== exp_vec() || dl_if.step_right !== (i == 8)) begin
        n_err++;
        $display("FAIL reset_mid post cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit l, rr, f, r;
    int bias;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bias = ((i / 400) % 2 == 0) ? 7 : 3;
      rr = ($urandom_range(0, 9) < bias);
      l  = ($urandom_range(0, 9) >= bias);
      f  = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 499) == 0);
      cycle(r, l, rr, f);
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    dl_if.shift_left  = 1'b0;
    dl_if.shift_right = 1'b0;
    dl_if.freeze      = 1'b0;
    test_reset();
    test_right_step();
    test_null_votes();
    test_left_saturate();
    test_relock();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/delay_line_controller.md
DELAY_LINE_CONTROLLER -- requirements
Module: delay_line_controller

Interface
REQ-001 Parameter N_TAPS, default 32: number of delay-line taps; TAP_W = clog2(N_TAPS) = 5.
REQ-002 Parameter FILT_TH, default 8: random-walk filter threshold, magnitude.
REQ-003 Parameter LOCK_CYCLES, default 64: consecutive step-free cycles required to declare lock.
REQ-004 Parameter TAP_RESET, default N_TAPS/2 = 16: tap selected after reset.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 shift_left  input  1  phase-detector request to move sampling phase earlier (one vote per cycle).
REQ-008 shift_right  input  1  phase-detector request to move sampling phase later (one vote per cycle).
REQ-009 freeze  input  1  when high, filter, tap and lock counter hold their values.
REQ-010 tap_sel  output  TAP_W  registered delay-line tap select driving the delay-line mux.
REQ-011 step_left / step_right  output  1 each  single-cycle pulse, asserted on the edge tap_sel decrements / increments.
REQ-012 at_min / at_max  output  1 each  registered: tap_sel == 0 / tap_sel == N_TAPS-1.
REQ-013 locked  output  1  registered lock indication.

Function
REQ-014 Filter: signed accumulator acc, range -FILT_TH..+FILT_TH; per unfrozen cycle: right-only -> acc+1, left-only -> acc-1, both or neither -> hold.
REQ-015 When the next acc value equals +FILT_TH: acc <= 0 and, on the same edge, tap_sel <= tap_sel+1 and step_right pulses; symmetrically -FILT_TH -> tap_sel-1, step_left.
REQ-016 Latency: tap_sel changes on the clock edge that samples the threshold-reaching vote; no additional pipeline stage.
REQ-017 Saturation: threshold toward +1 with tap_sel == N_TAPS-1 (or toward -1 with tap_sel == 0) clears acc, leaves tap_sel unchanged, no step pulse; tap_sel never wraps.
REQ-018 Simultaneous shift_left and shift_right are a null vote (REQ-014), never an error.
REQ-019 FSM states ACQ and LOCK; reset enters ACQ.
REQ-020 lock_cnt increments each unfrozen cycle without a step pulse, saturating at LOCK_CYCLES; any step pulse clears it to 0.
REQ-021 ACQ -> LOCK on the edge lock_cnt reaches LOCK_CYCLES; LOCK -> ACQ on any step pulse; locked = (state == LOCK), registered.
REQ-022 Saturated-threshold events (REQ-017) count as steps for lock purposes: clear lock_cnt and force ACQ.
REQ-023 freeze high: acc, tap_sel, lock_cnt, state hold; step pulses 0; votes ignored.

Reset
REQ-024 On rst: tap_sel = TAP_RESET, acc = 0, lock_cnt = 0, state = ACQ, locked = 0, step_left = step_right = 0, at_min = at_max = 0 (for default TAP_RESET).
REQ-025 rst mid-operation overrides freeze and any vote in the same cycle; first vote counted is the cycle after rst deasserts.

Structure
REQ-026 Package cdr_pkg holds N_TAPS, TAP_W, FILT_TH, LOCK_CYCLES, TAP_RESET defaults and the ACQ/LOCK state encoding, shared with the phase detector top.
REQ-027 One sub-module rw_filter (votes in, acc, up/down threshold pulses out); tap pointer, lock counter and FSM stay in delay_line_controller.

Verification
REQ-028 Reset then 8 cycles shift_right=1 -> tap_sel 16->17 on 8th sampling edge, one step_right pulse, acc back to 0.
REQ-029 Alternating left/right for 100 cycles, then both high 20 cycles -> tap_sel stays 16, no step pulses, locked=1 from cycle 64.
REQ-030 Continuous shift_left 200 cycles -> tap_sel decrements every 8 cycles to 0, at_min=1, no further change or step pulse, locked=0 throughout.
REQ-031 Locked state, then 8 cycles shift_right -> step_right pulse, locked falls on the same edge, relocks 64 step-free cycles later.
REQ-032 freeze=1 during 20 cycles shift_right -> tap_sel, acc unchanged; after freeze drops, 8 more votes needed for a step.
REQ-033 rst asserted with acc=+7 and tap_sel=20 -> next edge tap_sel=16, acc=0, locked=0; an 8th vote on that edge causes no step.
